// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq -- multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
//
// The unit owns the architectural HI/LO registers. An operation takes 33 busy
// cycles: 32 shift-add (multiply) or restoring (divide) steps on magnitudes,
// then one FIX cycle that applies signs and commits HI/LO. It also serves
// MTHI/MTLO writes, and it stalls the pipeline when EX needs the unit while busy.
//
// Optional feature: define MULDIV_ABORT_EN to add the 'abort' input. It flushes
// an in-flight operation without touching HI/LO.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       EX holds a mult/div (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   op_a, op_b      rs / rt operands
//   rd_hilo         EX holds MFHI/MFLO
//   wr_hi, wr_lo    MTHI / MTLO strobes, data on wdata
//   abort           (MULDIV_ABORT_EN only) flush the in-flight operation
//   hi, lo          committed HI / LO registers
//   busy            operation in flight (ITER or FIX)
//   done            one-cycle pulse in the FIX cycle
//   stall           freeze IF/ID/EX (combinational)
module ex_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_hilo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_r;     // multiply: product high half / divide: remainder
  logic [WIDTH-1:0] low_r;     // multiply: multiplier / product low half; divide: quotient
  logic [WIDTH-1:0] opnd_r;    // multiply: multiplicand magnitude; divide: divisor magnitude
  logic [1:0]       op_r;
  logic             sign_a_r, sign_b_r, dz_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             abort_s;

`ifdef MULDIV_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes at capture; unsigned ops take the raw values.
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  assign a_neg_s = ~op[0] & op_a[WIDTH-1];
  assign b_neg_s = ~op[0] & op_b[WIDTH-1];
  assign mag_a_s = a_neg_s ? negate(op_a) : op_a;
  assign mag_b_s = b_neg_s ? negate(op_b) : op_b;

  // One iteration step of the selected algorithm.
  logic [WIDTH:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic [WIDTH-1:0] acc_nxt_s, low_nxt_s;
  always_comb begin
    mul_sum_s  = {1'b0, acc_r} + (low_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_r, low_r[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, opnd_r};
    if (op_r[1]) begin
      if (!div_diff_s[WIDTH]) begin
        acc_nxt_s = div_diff_s[WIDTH-1:0];
        low_nxt_s = {low_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_s = div_sh_s[WIDTH-1:0];
        low_nxt_s = {low_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt_s = mul_sum_s[WIDTH:1];
      low_nxt_s = {mul_sum_s[0], low_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final result, committed at the end of FIX.
  logic             neg_res_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0] quo_fix_s, rem_fix_s, hi_fix_s, lo_fix_s;
  always_comb begin
    neg_res_s  = ~op_r[0] & (sign_a_r ^ sign_b_r);
    prod_s     = {acc_r, low_r};
    prod_fix_s = neg_res_s ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
    quo_fix_s  = neg_res_s ? negate(low_r) : low_r;
    rem_fix_s  = (~op_r[0] & sign_a_r) ? negate(acc_r) : acc_r;
    if (op_r[1]) begin
      // With a zero divisor every trial subtract succeeds, so the remainder
      // path rebuilds op_a exactly (sign restored); only LO needs overriding.
      hi_fix_s = rem_fix_s;
      lo_fix_s = dz_r ? {WIDTH{1'b1}} : quo_fix_s;
    end else begin
      hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: if (start) state_nxt_s = ITER; else state_nxt_s = IDLE;
      ITER: begin
        if (abort_s)                        state_nxt_s = IDLE;
        else if (cnt_r == CW'(STEPS - 1))   state_nxt_s = FIX;
        else                                state_nxt_s = ITER;
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      IDLE: busy = 1'b0;
      ITER: busy = 1'b1;
      FIX: begin
        busy = 1'b1;
        done = ~abort_s;
      end
      default: busy = 1'b0;
    endcase
  end

  assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);
  assign hi    = hi_r;
  assign lo    = lo_r;

  // Datapath: operand capture, iteration, HI/LO commit and MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {WIDTH{1'b0}};
      low_r    <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      op_r     <= 2'b00;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      dz_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r    <= {WIDTH{1'b0}};
            low_r    <= op[1] ? mag_a_s : mag_b_s;
            opnd_r   <= op[1] ? mag_b_s : mag_a_s;
            op_r     <= op;
            sign_a_r <= a_neg_s;
            sign_b_r <= b_neg_s;
            dz_r     <= (op_b == {WIDTH{1'b0}});
            cnt_r    <= {CW{1'b0}};
          end else begin
            if (wr_hi) hi_r <= wdata;
            if (wr_lo) lo_r <= wdata;
          end
        end
        ITER: begin
          acc_r <= acc_nxt_s;
          low_r <= low_nxt_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          if (!abort_s) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
          end
        end
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = 32'd0, op_b = 32'd0, wdata = 32'd0;
  logic        rd_hilo = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .rd_hilo(rd_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = 64'(a) * 64'(b);
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Transaction-level model: remaining busy cycles plus a pending result.
  int          m_cnt;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_hi <= 32'd0; m_lo <= 32'd0; m_pend <= 64'd0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend <= ref_result(op, op_a, op_b);
        m_cnt  <= 33;
      end else begin
        if (wr_hi) m_hi <= wdata;
        if (wr_lo) m_lo <= wdata;
      end
    end else if (abort) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("busy", 32'(busy), 32'(m_cnt != 0));
      check("done", 32'(done), 32'((m_cnt == 1) && !abort));
      check("stall", 32'(stall), 32'((m_cnt != 0) && (start || rd_hilo || wr_hi || wr_lo)));
    end
  end

  // Called just after a clock edge; returns just after E33.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk); #1 start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  int nb, nd, di;
  bit found;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // MTHI and MTLO in the same cycle.
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1 wr_hi = 1'b0; wr_lo = 1'b0;
    check("mt_hi", hi, 32'h1234_5678);
    check("mt_lo", lo, 32'h1234_5678);

    // MULTU max*max with occupancy and done timing.
    start = 1'b1; op = 2'b01; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b0;
    nb = 0; nd = 0; di = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) begin nd++; di = i; end
      @(posedge clk); #1;
    end
    check("multu_busy_cycles", 32'(nb), 32'd33);
    check("multu_done_count", 32'(nd), 32'd1);
    check("multu_done_cycle", 32'(di), 32'd32);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_zero");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");

    // Requests while busy: stalled, not recaptured, retried after E33.
    start = 1'b1; op = 2'b01; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = 2'b11; op_a = 32'd9; op_b = 32'd3; rd_hilo = 1'b1;
    #1 check("stall_busy_req", 32'(stall), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy) begin found = 1'b1; break; end
    end
    check("retry_wait", 32'(found), 32'd1);
    check("retry_stall_idle", 32'(stall), 32'd0);
    check("mul42_hi", hi, 32'd0);
    check("mul42_lo", lo, 32'd42);
    @(posedge clk); #1 start = 1'b0; rd_hilo = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("divu93_hi", hi, 32'd0);
    check("divu93_lo", lo, 32'd3);

`ifdef MULDIV_ABORT_EN
    wr_hi = 1'b1; wdata = 32'h0000_000A;
    @(posedge clk); #1 wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'h0000_000B;
    @(posedge clk); #1 wr_lo = 1'b0;
    start = 1'b1; op = 2'b11; op_a = 32'd50; op_b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    check("abort_hi", hi, 32'h0000_000A);
    check("abort_lo", lo, 32'h0000_000B);
`endif

    // Random traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 5) == 0);
      op      = 2'($urandom_range(0, 3));
      op_a    = $urandom;
      op_b    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin op_a = 32'h8000_0000; op_b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) op_b = 32'($urandom_range(0, 9));
      rd_hilo = ($urandom_range(0, 3) == 0);
      wr_hi   = ($urandom_range(0, 7) == 0);
      wr_lo   = ($urandom_range(0, 7) == 0);
      wdata   = $urandom;
`ifdef MULDIV_ABORT_EN
      abort   = ($urandom_range(0, 63) == 0);
`endif
    end
    @(posedge clk); #1;
    start = 1'b0; rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; abort = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    // Give HI/LO a nonzero value so the reset check below means something.
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 wr_hi = 1'b0; wr_lo = 1'b0;

    // Reset in the middle of a MULTU.
    start = 1'b1; op = 2'b01; op_a = 32'h0001_FFFF; op_b = 32'h0000_FFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 32'(nd), 32'd0);
    check("midrst_hi_after", hi, 32'd0);
    check("midrst_lo_after", lo, 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage, sitting beside the single-cycle ALU.
- Runs a 32-step shift-add multiply or restoring divide and owns the architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall toward the pipeline control whenever an EX-stage instruction needs the unit while it is busy.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- STEPS, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX holds a mult/div instruction this cycle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op_a  input  32  rs operand (multiplicand / dividend)
- op_b  input  32  rt operand (multiplier / divisor)
- rd_hilo  input  1  EX holds MFHI or MFLO
- wr_hi  input  1  MTHI
- wr_lo  input  1  MTLO
- wdata  input  32  MTHI/MTLO data
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse, final (FIX) cycle
- stall  output  1  freeze IF/ID/EX this cycle

Behaviour:
Interface:
- One clock, clk.
- Reset is asynchronous and active-low, rst_n.

Reset:
- state=IDLE; hi=0, lo=0; busy=0, done=0, stall=0; step counter=0.

FSM states: IDLE, ITER, FIX.

IDLE:
- start=1 at edge E0: capture |op_a| and |op_b| (raw values for unsigned ops), op, the sign bits and a divisor-zero flag; counter=0; go to ITER.
- wr_hi / wr_lo with no start: write wdata into hi / lo at that edge. Both may be set in the same cycle.
- start together with wr_hi/wr_lo: start wins; the writes are dropped.

ITER:
- One step per edge, E1..E32.
- Multiply: 64-bit {acc,mplr}; add the multiplicand to acc when the mplr LSB is 1; shift right 1.
- Divide: shift {rem,quo} left 1; trial subtract the divisor; if the result is non-negative, keep it and set quo LSB=1.
- After the edge where counter reaches 31 (E32), go to FIX.

FIX (single cycle after E32):
- done=1.
- Signed multiply: negate the 64-bit product if sign_a^sign_b.
- Signed divide: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
- At edge E33: hi <= upper/remainder, lo <= lower/quotient; go to IDLE.
- New values are visible from the cycle after E33. Total occupancy is 33 cycles.

Divide by zero (signed or unsigned):
- lo=0xFFFFFFFF, hi=op_a as captured, with no sign fix.

Overflow:
- Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (falls out of the magnitude path; no special case).

busy:
- Asserted in ITER and FIX.

stall (combinational):
- stall = busy & (start | rd_hilo | wr_hi | wr_lo).
- Never asserted in IDLE.

While busy:
- start, wr_hi and wr_lo are ignored; no operand recapture.
- The requester is held by stall and retries in the IDLE cycle that follows E33.
- Consequently a back-to-back mult/div begins at the edge after E33.

hi/lo outputs:
- Always show the committed registers; never intermediate values.

Reset mid-operation:
- Immediate return to IDLE with hi=lo=0 and done=0.
- No partial result is written.

Optional Feature:
Macro MULDIV_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in ITER or FIX returns the FSM to IDLE at the next edge.
  - hi/lo are left unchanged and done is suppressed that cycle.
  - abort has priority over the FIX write.
  - abort in IDLE has no effect.
  - Used for exception/branch flush of the EX instruction.
- Undefined: no abort port; an operation, once started, always completes.

Test Plan:
- MULTU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> done pulses in the cycle after E32; after E33 hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT op_a=0xFFFFFFFD (-3), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU op_a=100, op_b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV op_a=0x80000000, op_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 6*7; at E5 drive start (DIVU 9/3) and rd_hilo -> stall=1 both cycles, no operand recapture; after E33 hi=0, lo=42; the retried DIVU started at the following edge gives lo=3, hi=0.
- wr_hi=1 and wr_lo=1 with wdata=0x12345678 in IDLE -> both registers read 0x12345678. Deassert rst_n at E10 of a MULTU -> immediate IDLE, hi=lo=0, done never pulses.
- With MULDIV_ABORT_EN: preload hi=0xA, lo=0xB; start DIVU 50/5; abort at E20 -> IDLE next edge, hi=0xA, lo=0xB, no done pulse.
